// File: rtl/vga_textbox.sv
// Text-box component for the VGA font pipeline: maps pixel position to a character
// address, fetches with one cycle of latency and overlays a frame-synchronous blinking cursor.
`ifndef WHITE
`define WHITE 3'b111
`endif
`ifndef BLACK
`define BLACK 3'b000
`endif

module vga_textbox #(
  parameter logic [9:0]        LINE         = 10'd0,
  parameter logic [9:0]        COL          = 10'd0,
  parameter int                WIDTH        = 1,
  parameter int                HEIGHT       = 1,
  parameter int                PZOOM        = 0,
  parameter logic [2:0]        PCOLOR       = `WHITE,
  parameter int                ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] OFFSET       = '0,
  parameter logic              H2A          = 1'b0,
  parameter int                BLINK_FRAMES = 30
) (
  input  logic              px_clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              en,
  input  logic              cursor_en,
  input  logic [7:0]        cursor_x,
  input  logic [7:0]        cursor_y,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic [2:0]        color,
  output logic [1:0]        zoom,
  output logic              h2a
);

  localparam int              SHIFT    = 3 + PZOOM;
  localparam logic [10:0]     COL_END  = 11'(COL) + 11'(WIDTH);
  localparam logic [10:0]     ROW_END  = 11'(LINE) + 11'(HEIGHT);
  localparam int              CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [9:0]       cx, cy, rel_x, rel_y;
  logic [31:0]      addr_full;
  logic             active0, hit0, at0, frame_tick;

  logic             active_q, active_d;
  logic             hit_q, hit_d;
  logic             at0_q, at0_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;

  // Stage 0: cell lookup and cursor match, all relative to the component origin
  always_comb begin
    cx        = x >> SHIFT;
    cy        = y >> SHIFT;
    rel_x     = cx - COL;
    rel_y     = cy - LINE;
    active0   = en && (cx >= COL) && ({1'b0, cx} < COL_END)
                   && (cy >= LINE) && ({1'b0, cy} < ROW_END);
    addr_full = 32'(OFFSET) + 32'(rel_y) * 32'(WIDTH) + 32'(rel_x);
    addr      = active0 ? addr_full[ADDR_W-1:0] : '0;
    hit0      = active0 && cursor_en
                && (rel_x == {2'b00, cursor_x}) && (rel_y == {2'b00, cursor_y});
  end

  // Frame tick fires on the first cycle at (0,0), so a held origin counts once
  always_comb begin
    at0         = (x == 10'd0) && (y == 10'd0);
    frame_tick  = at0 && !at0_q;
    active_d    = active0;
    hit_d       = hit0;
    at0_d       = at0;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_tick) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      active_q    <= 1'b0;
      hit_q       <= 1'b0;
      at0_q       <= 1'b0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      active_q    <= active_d;
      hit_q       <= hit_d;
      at0_q       <= at0_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  // Stage 1: din arrives now for the cell fetched last cycle
  always_comb begin
    dout  = 8'h00;
    color = `BLACK;
    zoom  = 2'd0;
    h2a   = 1'b0;
    if (active_q) begin
      dout  = din ^ {8{hit_q & blink_on_q}};
      color = PCOLOR;
      zoom  = 2'(PZOOM);
      h2a   = H2A;
    end
  end

endmodule

// File: doc/vga_textbox.md
Name: vga_textbox

Overview:
- Multi-row, multi-column text component for the VGA font pipeline, parametrised in size, zoom, address width and colour.
- Maps the current pixel position to a character-memory address and fetches the character with one cycle of memory latency.
- Drives dout/color/zoom/h2a to the shared font renderer in the following cycle.
- Adds a frame-synchronous blinking cursor: the cursor cell is shown as inverse video (dout XOR 8'hFF).

Parameters:
- LINE, 10'd0: top edge of the component, in character rows.
- COL, 10'd0: left edge of the component, in character columns.
- WIDTH, 1: number of columns (1..255).
- HEIGHT, 1: number of rows (1..255).
- PZOOM, 0: zoom level (0..3); one cell is 8<<PZOOM pixels square.
- PCOLOR, `WHITE: 3-bit foreground colour.
- ADDR_W, 8: width of the memory address.
- OFFSET, 0: base address of cell (0,0), ADDR_W bits.
- H2A, 1'b0: value driven on h2a (hex-nibble translation request).
- BLINK_FRAMES, 30: frames per cursor blink phase (>=1).

Ports:
- px_clk  in  1  pixel clock.
- reset  in  1  asynchronous reset, active-high.
- x  in  10  current screen X.
- y  in  10  current screen Y.
- en  in  1  component enable.
- cursor_en  in  1  cursor display enable.
- cursor_x  in  8  cursor column, relative to the component.
- cursor_y  in  8  cursor row, relative to the component.
- addr  out  ADDR_W  character memory address (combinational).
- din  in  8  character from memory; valid one cycle after addr.
- dout  out  8  character to render.
- color  out  3  render colour.
- zoom  out  2  render zoom.
- h2a  out  1  hex-to-ASCII translation request.

Behaviour:
- Cell coordinates: cx = x>>(3+PZOOM), cy = y>>(3+PZOOM); rel_x = cx-COL, rel_y = cy-LINE, both 10-bit.
- Stage 0 (combinational):
  - active0 = en && COL<=cx<COL+WIDTH && LINE<=cy<LINE+HEIGHT.
  - addr = (OFFSET + rel_y*WIDTH + rel_x), truncated to ADDR_W (wraps modulo 2^ADDR_W); addr = 0 when !active0.
  - hit0 = active0 && cursor_en && rel_x==cursor_x && rel_y==cursor_y. A cursor outside the component never hits.
- Stage 1 registers (posedge px_clk): active1<=active0, hit1<=hit0.
- Outputs, combinational from stage-1 registers and din:
  - If active1: dout = din ^ {8{hit1 & blink_on}}, color = PCOLOR, zoom = PZOOM, h2a = H2A.
  - Else: dout = 0, color = `BLACK, zoom = 0, h2a = 0.
  - Latency from x/y to rendered outputs is exactly 1 cycle.
- Frame tick:
  - at0 = (x==0 && y==0); at0_q is registered at0.
  - frame_tick = at0 && !at0_q, so a position held at (0,0) for several cycles counts once.
- Blink:
  - blink_cnt counts 0..BLINK_FRAMES-1 and advances on frame_tick.
  - When it wraps to 0, blink_on toggles.
  - BLINK_FRAMES=1 toggles blink_on every frame.
- Reset (asynchronous, any time): active1=0, hit1=0, at0_q=0, blink_cnt=0, blink_on=1. All outputs therefore read the inactive values immediately; addr stays combinational.
- en drops mid-line: active0 and addr go inactive the same cycle; the stage-1 cell already in flight is still rendered.
- cursor_x/cursor_y/cursor_en are sampled in stage 0 only; a change takes effect from the next fetched cell.

Test Plan:
Configuration unless noted: COL=2, LINE=1, WIDTH=4, HEIGHT=3, PZOOM=0, OFFSET=8'h10, ADDR_W=8, cursor_en=0.
1. x=16, y=8 -> addr=8'h10. Next cycle with din=8'h41 -> dout=8'h41, color=PCOLOR, zoom=0, h2a=H2A.
2. x=40, y=24 (rel 3,2) -> addr=8'h1B. Then x=48, y=24 (cx=6, outside) -> addr=0; next cycle dout=0, color=`BLACK.
3. cursor_en=1, cursor=(1,0), BLINK_FRAMES=2, din=8'h41 at x=24, y=8:
   - after reset -> dout=8'hBE;
   - after 2 frame ticks -> dout=8'h41;
   - after 2 more -> 8'hBE.
   - Holding x=y=0 for 5 cycles counts 1 tick.
4. PZOOM=1, x=32, y=16 -> addr=8'h10; next cycle zoom=1. x=31 -> addr=0.
5. OFFSET=8'hFE, x=40, y=8 (rel 3,0) -> addr=8'h01 (wrap).
6. Assert reset while active1=1 and blink_on=0 -> outputs immediately dout=0, color=`BLACK. After release, the cursor cell shows inverted (blink_on=1).
